// File: rtl/heaa_pkg.sv
`default_nettype none
// ============================================================================
// heaa_pkg : shared widths, FSM states and counter helper for the HEAA accumulator
// Revision : 1.0
// ============================================================================
package heaa_pkg;

   localparam int DEFAULT_ADDER_LENGTH   = 32;
   localparam int DEFAULT_IMPRECISE_PART = 16;
   localparam int DEFAULT_COUNT_WIDTH    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } heaa_state_e;

   // All-ones value of a w-bit saturating counter.
   function automatic longint unsigned count_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   localparam longint unsigned DEFAULT_COUNT_MAX = count_max(DEFAULT_COUNT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/heaa_addsub_core.sv
`default_nettype none
// ============================================================================
// heaa_addsub_core : exact negation followed by one HEAA approximate add step
// Revision : 1.0
// ============================================================================
module heaa_addsub_core
   import heaa_pkg::*;
#(
   parameter int ADDER_LENGTH   = DEFAULT_ADDER_LENGTH,
   parameter int IMPRECISE_PART = DEFAULT_IMPRECISE_PART
) (
   input  logic [ADDER_LENGTH-1:0] x,
   input  logic [ADDER_LENGTH-1:0] y,
   input  logic                    sub,
   output logic [ADDER_LENGTH-1:0] r,
   output logic                    flag_event
);

   localparam int HI_W = ADDER_LENGTH - IMPRECISE_PART;

   logic [ADDER_LENGTH-1:0] w_y_eff;
   logic                    w_carry_k;
   logic [HI_W:0]           w_hi_sum;

   assign w_y_eff   = sub ? (~y + ADDER_LENGTH'(1)) : y;
   assign w_carry_k = x[IMPRECISE_PART-1] & w_y_eff[IMPRECISE_PART-1];

   assign w_hi_sum = {1'b0, x[ADDER_LENGTH-1:IMPRECISE_PART]}
                   + {1'b0, w_y_eff[ADDER_LENGTH-1:IMPRECISE_PART]}
                   + (HI_W+1)'(w_carry_k);

   // Top approximate bit drops to 0 when both inputs are set; that carry goes up exactly.
   assign r = {w_hi_sum[HI_W-1:0],
               x[IMPRECISE_PART-1] ^ w_y_eff[IMPRECISE_PART-1],
               x[IMPRECISE_PART-2:0] | w_y_eff[IMPRECISE_PART-2:0]};

   assign flag_event = sub ? (~w_hi_sum[HI_W] & (|y)) : w_hi_sum[HI_W];

endmodule
`default_nettype wire

// File: rtl/heaa_accumulator.sv
`default_nettype none
// ============================================================================
// heaa_accumulator : packetised HEAA add/sub accumulator with valid/ready result
// Revision : 1.0
// ============================================================================
module heaa_accumulator
   import heaa_pkg::*;
#(
   parameter int ADDER_LENGTH   = DEFAULT_ADDER_LENGTH,
   parameter int IMPRECISE_PART = DEFAULT_IMPRECISE_PART,
   parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDER_LENGTH-1:0] in_data,
   input  logic                    in_sub,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ADDER_LENGTH-1:0] out_data,
   output logic                    out_flag,
   output logic [COUNT_WIDTH-1:0]  out_count
);

   localparam logic [COUNT_WIDTH-1:0] C_COUNT_MAX = COUNT_WIDTH'(count_max(COUNT_WIDTH));

   heaa_state_e             state_q, state_d;
   logic [ADDER_LENGTH-1:0] acc_q, acc_d;
   logic                    flag_q, flag_d;
   logic [COUNT_WIDTH-1:0]  count_q, count_d;

   logic [ADDER_LENGTH-1:0] w_sum;
   logic                    w_flag_event;
   logic                    w_accept;

   heaa_addsub_core #(
      .ADDER_LENGTH   (ADDER_LENGTH),
      .IMPRECISE_PART (IMPRECISE_PART)
   ) u_core (
      .x          (acc_q),
      .y          (in_data),
      .sub        (in_sub),
      .r          (w_sum),
      .flag_event (w_flag_event)
   );

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign out_data  = acc_q;
   assign out_flag  = flag_q;
   assign out_count = count_q;
   assign w_accept  = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      flag_d  = flag_q;
      count_d = count_q;
      case (state_q)
         IDLE, ACC: begin
            if (w_accept) begin
               acc_d   = w_sum;
               flag_d  = flag_q | w_flag_event;
               count_d = (count_q == C_COUNT_MAX) ? count_q : count_q + COUNT_WIDTH'(1);
               state_d = in_last ? DONE : ACC;
            end
         end
         DONE: begin
            // Clearing here means IDLE always starts a packet from zero.
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               flag_d  = 1'b0;
               count_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
            flag_d  = 1'b0;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         flag_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         flag_q  <= flag_d;
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_heaa_accumulator.sv
`default_nettype none
// ============================================================================
// tb_heaa_accumulator : directed + randomized bench for heaa_accumulator (N=8, k=4)
// Revision : 1.0
// ============================================================================
module tb_heaa_accumulator;

   localparam int N  = 8;
   localparam int K  = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  in_data = '0;
   logic          in_sub = 1'b0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  out_data;
   logic          out_flag;
   logic [CW-1:0] out_count;

   int checks = 0;
   int failures = 0;

   logic [N-1:0] q_data[$];
   bit           q_sub[$];

   heaa_accumulator #(
      .ADDER_LENGTH   (N),
      .IMPRECISE_PART (K),
      .COUNT_WIDTH    (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flag  (out_flag),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   // Reference: arithmetic form of one HEAA step on integers.
   function automatic void heaa_ref(input int unsigned acc, input int unsigned d, input bit sub,
                                    output int unsigned r, output bit ev);
      int unsigned y, lo, b, hi;
      bit co;
      y  = sub ? ((1 << N) - d) % (1 << N) : d;
      lo = (acc | y) % (1 << (K - 1));
      b  = ((acc >> (K - 1)) & 1) + ((y >> (K - 1)) & 1);
      hi = (acc >> K) + (y >> K) + b / 2;
      co = (hi >= (1 << (N - K)));
      r  = (hi % (1 << (N - K))) * (1 << K) + (b % 2) * (1 << (K - 1)) + lo;
      ev = sub ? (!co && d != 0) : co;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sends the queued beats (last on the final one); leaves bench at the negedge after the last beat.
   task automatic drive_packet(input bit gaps, output bit valid_after);
      int n;
      n = q_data.size();
      for (int i = 0; i < n; i++) begin
         int w;
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = N'($urandom);
            in_last  = 1'b1;
            tick();
         end
         w = 0;
         while (!in_ready && w < 20) begin
            tick();
            w++;
         end
         checks++;
         if (!in_ready) begin
            failures++;
            $display("FAIL in_ready_timeout got=%0b exp=1", in_ready);
         end
         in_valid = 1'b1;
         in_data  = q_data[i];
         in_sub   = q_sub[i];
         in_last  = (i == n - 1);
         tick();
      end
      in_valid    = 1'b0;
      in_last     = 1'b0;
      valid_after = out_valid;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      checks++; if (out_data  !== 8'h00)  begin failures++; $display("FAIL rst_data got=%h exp=00", out_data); end
      checks++; if (out_flag  !== 1'b0)   begin failures++; $display("FAIL rst_flag got=%b exp=0", out_flag); end
      checks++; if (out_count !== 8'h00)  begin failures++; $display("FAIL rst_count got=%h exp=00", out_count); end
      checks++; if (in_ready  !== 1'b1)   begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_add_basic();
      bit v;
      q_data = '{8'h35, 8'h1B}; q_sub = '{0, 0};
      drive_packet(1'b0, v);
      checks++; if (v !== 1'b1)          begin failures++; $display("FAIL add_latency got=%b exp=1", v); end
      checks++; if (out_data !== 8'h4F)  begin failures++; $display("FAIL add_data got=%h exp=4f", out_data); end
      checks++; if (out_flag !== 1'b0)   begin failures++; $display("FAIL add_flag got=%b exp=0", out_flag); end
      checks++; if (out_count !== 8'd2)  begin failures++; $display("FAIL add_count got=%0d exp=2", out_count); end
      consume();
   endtask

   task automatic test_boundary();
      bit v;
      q_data = '{8'h0F, 8'h0F}; q_sub = '{0, 0};
      drive_packet(1'b0, v);
      checks++; if (out_data !== 8'h17)  begin failures++; $display("FAIL bnd_0f_data got=%h exp=17", out_data); end
      consume();
      q_data = '{8'h08, 8'h08}; q_sub = '{0, 0};
      drive_packet(1'b0, v);
      checks++; if (out_data !== 8'h10)  begin failures++; $display("FAIL bnd_08_data got=%h exp=10", out_data); end
      checks++; if (out_flag !== 1'b0)   begin failures++; $display("FAIL bnd_08_flag got=%b exp=0", out_flag); end
      consume();
   endtask

   task automatic test_subtract();
      bit v;
      q_data = '{8'h4F, 8'h10}; q_sub = '{0, 1};
      drive_packet(1'b0, v);
      checks++; if (out_data !== 8'h3F)  begin failures++; $display("FAIL sub_data got=%h exp=3f", out_data); end
      checks++; if (out_flag !== 1'b0)   begin failures++; $display("FAIL sub_flag got=%b exp=0", out_flag); end
      consume();
      q_data = '{8'h05, 8'h10}; q_sub = '{0, 1};
      drive_packet(1'b0, v);
      checks++; if (out_data !== 8'hF5)  begin failures++; $display("FAIL borrow_data got=%h exp=f5", out_data); end
      checks++; if (out_flag !== 1'b1)   begin failures++; $display("FAIL borrow_flag got=%b exp=1", out_flag); end
      consume();
   endtask

   task automatic test_backpressure();
      bit v;
      q_data = '{8'hF0, 8'h20}; q_sub = '{0, 0};
      drive_packet(1'b0, v);
      checks++; if (out_data !== 8'h10)  begin failures++; $display("FAIL ovf_data got=%h exp=10", out_data); end
      checks++; if (out_flag !== 1'b1)   begin failures++; $display("FAIL ovf_flag got=%b exp=1", out_flag); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = N'($urandom); in_sub = 1'($urandom); in_last = 1'($urandom);
         tick();
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
         checks++; if (out_data !== 8'h10) begin failures++; $display("FAIL hold_data cyc=%0d got=%h exp=10", i, out_data); end
         checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         checks++; if (out_count !== 8'd2) begin failures++; $display("FAIL hold_count cyc=%0d got=%0d exp=2", i, out_count); end
      end
      // A beat offered on the consume edge must be dropped.
      in_valid = 1'b1; in_data = 8'h01; in_sub = 1'b0; in_last = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL rel_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00)  begin failures++; $display("FAIL rel_data got=%h exp=00", out_data); end
      checks++; if (out_count !== 8'd0)  begin failures++; $display("FAIL rel_count got=%0d exp=0", out_count); end
      checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
      q_data = '{8'h22}; q_sub = '{0};
      drive_packet(1'b0, v);
      checks++; if (v !== 1'b1)          begin failures++; $display("FAIL next_latency got=%b exp=1", v); end
      checks++; if (out_data !== 8'h22)  begin failures++; $display("FAIL next_data got=%h exp=22", out_data); end
      checks++; if (out_count !== 8'd1)  begin failures++; $display("FAIL next_count got=%0d exp=1", out_count); end
      consume();
   endtask

   task automatic test_reset_mid();
      bit v;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'h33; in_sub = 1'b0; in_last = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (out_data !== 8'h00)  begin failures++; $display("FAIL mrst_data got=%h exp=00", out_data); end
      checks++; if (out_count !== 8'd0)  begin failures++; $display("FAIL mrst_count got=%0d exp=0", out_count); end
      checks++; if (out_flag !== 1'b0)   begin failures++; $display("FAIL mrst_flag got=%b exp=0", out_flag); end
      checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL mrst_valid got=%b exp=0", out_valid); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL mrst_in_ready got=%b exp=1", in_ready); end
      q_data = '{8'h01}; q_sub = '{0};
      drive_packet(1'b0, v);
      checks++; if (out_data !== 8'h01)  begin failures++; $display("FAIL mrst_next_data got=%h exp=01", out_data); end
      checks++; if (out_count !== 8'd1)  begin failures++; $display("FAIL mrst_next_count got=%0d exp=1", out_count); end
      consume();
   endtask

   task automatic test_saturate();
      bit v;
      q_data.delete(); q_sub.delete();
      for (int i = 0; i < 301; i++) begin
         q_data.push_back(8'h00);
         q_sub.push_back(1'b0);
      end
      drive_packet(1'b0, v);
      checks++; if (out_count !== 8'hFF) begin failures++; $display("FAIL sat_count got=%h exp=ff", out_count); end
      checks++; if (out_data !== 8'h00)  begin failures++; $display("FAIL sat_data got=%h exp=00", out_data); end
      checks++; if (out_flag !== 1'b0)   begin failures++; $display("FAIL sat_flag got=%b exp=0", out_flag); end
      consume();
   endtask

   task automatic test_random();
      for (int p = 0; p < 40; p++) begin
         int unsigned acc, r;
         bit flag, ev, v;
         int n, d;
         n = $urandom_range(1, 6);
         q_data.delete(); q_sub.delete();
         acc = 0; flag = 0;
         for (int i = 0; i < n; i++) begin
            q_data.push_back(N'($urandom));
            q_sub.push_back(1'($urandom));
            heaa_ref(acc, q_data[i], q_sub[i], r, ev);
            acc  = r;
            flag = flag | ev;
         end
         drive_packet(1'b1, v);
         checks++; if (v !== 1'b1)           begin failures++; $display("FAIL rnd_latency pkt=%0d got=%b exp=1", p, v); end
         d = $urandom_range(0, 3);
         for (int c = 0; c < d; c++) tick();
         checks++; if (out_data !== N'(acc)) begin failures++; $display("FAIL rnd_data pkt=%0d got=%h exp=%h", p, out_data, N'(acc)); end
         checks++; if (out_flag !== flag)    begin failures++; $display("FAIL rnd_flag pkt=%0d got=%b exp=%b", p, out_flag, flag); end
         checks++; if (out_count !== CW'(n)) begin failures++; $display("FAIL rnd_count pkt=%0d got=%0d exp=%0d", p, out_count, n); end
         consume();
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_add_basic();
      test_boundary();
      test_subtract();
      test_backpressure();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/heaa_accumulator.md
# heaa_accumulator

- Streaming accumulator built on HEAA approximate arithmetic, with a sequential add/subtract path.
- Sums or subtracts a packet of operands using the HEAA rule (OR-approximated lower bits, exact upper bits), then presents one result per packet on a valid/ready output.
- Sits between a PE column's partial-sum stream and the output drain of the approximate TPU datapath.

## Interface
Parameters:
- ADDER_LENGTH, 32, operand and accumulator width.
- IMPRECISE_PART, 16, number of approximated low bits; legal range 2..ADDER_LENGTH-1.
- COUNT_WIDTH, 8, width of the beat counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  ADDER_LENGTH  operand.
- in_sub  in  1  1 = subtract operand from accumulator; 0 = add.
- in_last  in  1  final beat of the packet.
- out_valid  out  1  packet result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ADDER_LENGTH  accumulated result.
- out_flag  out  1  sticky overflow/borrow for the packet.
- out_count  out  COUNT_WIDTH  beats accepted in the packet, saturating.

## Operation
- HEAA step f(x,y), with k = IMPRECISE_PART:
  - r[k-2:0] = x|y.
  - r[k-1] = 0 if x[k-1]&y[k-1], else x[k-1]|y[k-1].
  - c = x[k-1]&y[k-1].
  - {co, r[N-1:k]} = x[N-1:k] + y[N-1:k] + c.
- Add beat: acc <= f(acc, in_data).
- Subtract beat: acc <= f(acc, (~in_data+1) mod 2^N).
  - Negation is exact; only the addition is approximate.
- Flag update for each beat; the flag is sticky for the packet:
  - Add beat: set when co = 1.
  - Subtract beat: set when co = 0 and in_data != 0.
- Result wraps modulo 2^ADDER_LENGTH. Never saturates.
- Count increments on every accepted beat and holds at 2^COUNT_WIDTH-1.
- States:
  - IDLE: acc = 0, flag = 0, count = 0, in_ready = 1.
    - Beat accepted with in_last = 0: update registers, go to ACC.
    - Beat accepted with in_last = 1: go to DONE.
  - ACC: in_ready = 1.
    - Each accepted beat updates registers.
    - Accepted beat with in_last = 1: go to DONE.
  - DONE: in_ready = 0, out_valid = 1; out_data, out_flag and out_count hold stable.
    - When out_ready = 1: go to IDLE and clear acc, flag and count in the same edge.
- A beat is accepted only when in_valid & in_ready. in_data, in_sub and in_last are ignored otherwise.

## Timing
- Reset (asynchronous, any state, including mid-packet):
  - State goes to IDLE; acc, flag and count clear.
  - Outputs: out_valid = 0, out_data = 0, out_flag = 0, out_count = 0, in_ready = 1 once rst deasserts.
  - A partially accumulated packet is discarded.
- Throughput: one beat per cycle while in IDLE/ACC.
- Latency: out_valid rises the cycle after the last beat is accepted, and out_data already includes that beat.
- Result handshake:
  - out_valid stays high until out_ready; it is never withdrawn.
  - out_valid and out_data change only in the cycle after the handshake.
- No new beat is accepted in the cycle the result is consumed. in_ready returns the cycle after.
  - Minimum packet period: single-beat packet = 2 cycles; n-beat packet = n+1 cycles.
- in_ready is a registered state decode, with no combinational path from out_ready.
- The arithmetic is single-cycle combinational feeding the acc register.

## Structure
- Shared package heaa_pkg holds:
  - the state enum (IDLE, ACC, DONE);
  - default widths;
  - a helper constant for the counter maximum.
- One combinational sub-module, heaa_addsub_core:
  - Inputs: x, y, sub.
  - Outputs: r, flag_event.
  - Contains the exact negation and the HEAA step.
  - Also reusable by other PE datapaths.
- Top level holds the FSM, registers, counter and handshake.

## Test plan
All scenarios use ADDER_LENGTH = 8, IMPRECISE_PART = 4.
1. Add 0x35, then add 0x1B with last -> out_data = 0x4F (exact sum 0x50), flag 0, count 2; out_valid exactly one cycle after the last beat.
2. Single add 0x0F, then add 0x0F with last -> out_data = 0x17; add 0x08 + 0x08 -> 0x10 (boundary-bit carry path).
3. Add 0x4F, then subtract 0x10 with last -> 0x3F, flag 0. Separate packet: add 0x05, subtract 0x10 -> 0xF5, flag 1 (borrow).
4. Add 0xF0 + 0x20 -> 0x10, flag 1.
   - Hold out_ready low for 5 cycles: out_valid/out_data stable, in_ready = 0, input beats ignored.
   - Release out_ready: next packet starts from acc = 0, and its first beat is accepted no earlier than the following cycle.
5. Assert rst mid-packet after 3 beats -> all outputs 0, in_ready = 1. The next packet of add 0x01 with last -> out_data = 0x01, count 1.
6. 300 add beats of 0x00 then last -> count saturates at 0xFF, out_data = 0x00, flag 0.
